// File: rtl/u_muldiv.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, 32 iterations each.
// Build option U_MULDIV_FAST_MUL_EN: multiplies finish on the accept edge through a single-cycle product.
module u_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_i1,
  input  logic [31:0] md_i2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] md_o,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a request is taken on a rising edge with in_valid && in_ready;
  // a result is taken on a rising edge with out_valid && out_ready.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;

  logic        a_signed, b_signed, a_neg, b_neg, neg_new;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next, acc_step;
  logic        div_ge;
  logic [31:0] div_trial;

  // Turns the unsigned magnitude result into the architectural value for op.
  function automatic logic [31:0] finalize(input logic [2:0] op, input logic neg,
                                           input logic [63:0] raw);
    logic [63:0] prod;
    logic [31:0] quo, rem;
    prod = neg ? (64'd0 - raw) : raw;
    quo  = neg ? (32'd0 - raw[31:0]) : raw[31:0];
    rem  = neg ? (32'd0 - raw[63:32]) : raw[63:32];
    if (op[2]) finalize = op[1] ? rem : quo;
    else       finalize = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  assign a_signed = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
  assign b_signed = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
  assign a_neg    = a_signed & md_i1[31];
  assign b_neg    = b_signed & md_i2[31];
  assign a_mag    = a_neg ? (32'd0 - md_i1) : md_i1;
  assign b_mag    = b_neg ? (32'd0 - md_i2) : md_i2;
  // Remainder follows the dividend; everything else follows the operand signs.
  assign neg_new  = (md_op[2] && md_op[1]) ? a_neg : (a_neg ^ b_neg);

  // Multiply step: acc = {partial high, multiplier bits still to consume}.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
  assign div_ge    = acc_q[63:31] >= {1'b0, b_q};
  assign div_trial = acc_q[62:31] - b_q;
  assign div_next  = div_ge ? {div_trial, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

  assign acc_step = op_q[2] ? div_next : mul_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = md_op;
          neg_d = neg_new;
          cnt_d = 6'd0;
          if (md_op[2] && (md_i2 == 32'd0)) begin
            res_d   = md_op[1] ? md_i1 : 32'hFFFF_FFFF;
            state_d = ST_DONE;
          end else if (md_op[2] && !md_op[0] && (md_i1 == 32'h8000_0000) &&
                       (md_i2 == 32'hFFFF_FFFF)) begin
            res_d   = md_op[1] ? 32'd0 : 32'h8000_0000;
            state_d = ST_DONE;
`ifdef U_MULDIV_FAST_MUL_EN
          end else if (!md_op[2]) begin
            res_d   = finalize(md_op, neg_new, {32'd0, a_mag} * {32'd0, b_mag});
            state_d = ST_DONE;
`endif
          end else begin
            b_d     = md_op[2] ? b_mag : a_mag;
            acc_d   = {32'd0, md_op[2] ? a_mag : b_mag};
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          res_d   = finalize(op_q, neg_q, acc_step);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_d   = 32'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign md_o      = out_valid ? res_q : 32'd0;

endmodule

// File: tb/tb_u_muldiv.sv
// Bench for u_muldiv: directed vector table, random ops against a reference model, and
// hand-written backpressure / consume-edge / mid-operation reset sequences.
module tb_u_muldiv;

`ifdef U_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_i1 = 32'd0;
  logic [31:0] md_i2 = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] md_o;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // lat = rising edges after the accept edge until out_valid is seen (0: DONE on the accept edge)
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vecs[15];

  u_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_op     (md_op),
    .md_i1     (md_i1),
    .md_i2     (md_i2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md_o      (md_o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb, sq;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    up  = {32'd0, a} * {32'd0, b};
    sp  = 64'sd0;
    ref_model = 32'd0;
    case (op)
      3'b000: ref_model = up[31:0];
      3'b001: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        ref_model = sp[63:32];
      end
      3'b010: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
        ref_model = sp[63:32];
      end
      3'b011: ref_model = up[63:32];
      3'b100: begin
        if (b == 32'd0) ref_model = 32'hFFFF_FFFF;
        else if (ovf) ref_model = 32'h8000_0000;
        else begin
          sq = sa / sb;
          ref_model = sq;
        end
      end
      3'b101: ref_model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) ref_model = a;
        else if (ovf) ref_model = 32'd0;
        else begin
          sq = sa % sb;
          ref_model = sq;
        end
      end
      default: ref_model = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 0;
    if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 0;
    return 32;
  endfunction

  // Presents one request at a falling edge, returns #1 after the accept edge.
  task automatic drive_req(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
    md_op    = op;
    md_i1    = a;
    md_i2    = b;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    md_op    = 3'($urandom_range(0, 7));
    md_i1    = $urandom;
    md_i2    = $urandom;
    check({name, " accepted"}, 32'(in_ready), 32'd0);
  endtask

  // Waits for the result, checks latency/value, applies backpressure, then consumes it.
  task automatic collect(input string name, input int lat, input int hold);
    int          n;
    bit          clean;
    logic [31:0] got;
    n = 0;
    clean = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0 || md_o !== 32'd0) clean = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " quiet while busy"}, 32'(clean), 32'd1);
    check({name, " latency"}, 32'(n), 32'(lat));
    got = md_o;
    if (exp_q.size() > 0) check({name, " result"}, got, exp_q.pop_front());
    else check({name, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
    clean = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (md_o !== got || out_valid !== 1'b1 || in_ready !== 1'b0) clean = 1'b0;
    end
    if (hold > 0) check({name, " stable under backpressure"}, 32'(clean), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " released {out_valid,in_ready}"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({name, " md_o cleared"}, md_o, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    drive_req(name, op, a, b, exp);
    collect(name, lat, hold);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          quiet;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, 0};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32,      0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32,      10};
    vecs[6]  = '{3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 0,       0};
    vecs[7]  = '{3'b111, 32'd100,        32'd0,         32'd100,       0,       0};
    vecs[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0,       0};
    vecs[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0,       0};
    vecs[10] = '{3'b001, 32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFF, MUL_LAT, 0};
    vecs[11] = '{3'b111, 32'h1234_5678,  32'h100,       32'h78,        32,      0};
    vecs[12] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32,      0};
    vecs[13] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         32,      0};
    vecs[14] = '{3'b000, 32'h0001_0001,  32'h0001_0001, 32'h0002_0001, MUL_LAT, 3};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset md_o", md_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, vecs[i].hold);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3))  : $urandom;
      if ($urandom_range(0, 7) == 0) rb = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom)};
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb),
             lat_of(rop, ra, rb), 0);
    end

    // A request waiting on the consume edge must not be taken until the following edge.
    drive_req("consume-edge remu0", 3'b111, 32'd50, 32'd0, 32'd50);
    check("consume-edge immediate done", 32'(out_valid), 32'd1);
    check("consume-edge first result", md_o, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b1;
    md_op     = 3'b101;
    md_i1     = 32'd20;
    md_i2     = 32'd4;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consume-edge no accept {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'd1);
    exp_q.push_back(32'd5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("consume-edge next accepted", 32'(in_ready), 32'd0);
    collect("consume-edge divu", 32, 0);

    // Reset pulse while BUSY at iteration 15 discards the operation.
    drive_req("reset-mid divu", 3'b101, 32'd1000, 32'd7, 32'd142);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset-mid {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'd1);
    check("reset-mid md_o", md_o, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    check("reset-mid no stale result", 32'(quiet), 32'd1);
    run_op("post-reset divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 32, 0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
